disp_scheduler: RTL and testbench
=================================

DISP_SCHEDULER -- requirements
Module: disp_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 5000: clk5 cycles per hold tick (1 ms at 5 MHz); legal range 2..65535.
REQ-002 Parameter HOLD_TICKS, default 500: ticks a granted value stays on the display; legal range 1..1023.
REQ-003 Parameter IDLE_VAL, default 16'h0000: value shown when idle with the idle feature enabled.
REQ-004 clk5  input  1  sole clock; all logic is on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  2  request from requester i (bit i); level, held until ack.
REQ-007 val0, val1  input  16 each  value offered by requester 0 and requester 1.
REQ-008 pt0, pt1  input  4 each  decimal-point mask offered by requester 0 and requester 1.
REQ-009 ack  output  2  one-cycle pulse to the requester whose value was latched.
REQ-010 dispVal  output  16  registered value driving the display interface.
REQ-011 point  output  4  registered decimal-point mask driving the display interface.
REQ-012 busy  output  1  high while in LOAD or HOLD.
REQ-013 owner  output  1  index of the last granted requester.

Function
REQ-014 The FSM SHALL have three states: IDLE, LOAD and HOLD.
REQ-015 IDLE: if any req bit is high, the block SHALL select a winner and go to LOAD on the next edge; otherwise it stays in IDLE.
REQ-016 Winner selection: if one bit is high, that requester wins; if both are high, the requester not equal to owner wins (round-robin).
REQ-017 LOAD (one cycle): the block SHALL register the winner's val/pt into dispVal/point, pulse ack[winner] for that cycle, update owner, clear the hold counter, then go to HOLD.
REQ-018 dispVal/point SHALL change one cycle after LOAD is entered; ack and the new dispVal SHALL become visible on the same edge.
REQ-019 Tick generator: a free-running counter of 0..TICK_DIV-1 SHALL assert a one-cycle tick when it equals TICK_DIV-1, then wrap to 0.
REQ-020 HOLD: the hold counter SHALL increment on each tick; when the counter reaches HOLD_TICKS, the FSM SHALL go to IDLE on the next edge.
REQ-021 Hold duration SHALL be between (HOLD_TICKS-1)*TICK_DIV+1 and HOLD_TICKS*TICK_DIV cycles.
REQ-022 Requests arriving during LOAD/HOLD, including from the current owner, SHALL be ignored until IDLE; no ack SHALL be issued.
REQ-023 A requester dropping req before ack SHALL forfeit; a request seen in IDLE is committed once LOAD is entered.
REQ-024 Without the idle feature, dispVal/point SHALL retain the last granted value while in IDLE.
REQ-025 The hold counter width SHALL be clog2(HOLD_TICKS+1); the tick counter width SHALL be clog2(TICK_DIV); the counter SHALL never exceed HOLD_TICKS.
REQ-026 At most one ack bit SHALL be high in any cycle.

Reset
REQ-027 Under reset: FSM=IDLE, dispVal=16'h0000, point=4'h0, ack=2'b00, busy=0, owner=1 (so requester 0 wins the first tie), and both counters=0.
REQ-028 Reset asserted mid-LOAD or mid-HOLD SHALL abort the sequence with no ack pulse on the following cycle.

Configuration
REQ-029 Macro DISP_SCHED_IDLE_PATTERN_EN: when defined, on every entry to IDLE with req==2'b00, dispVal SHALL load IDLE_VAL and point SHALL load 4'h0 on the next edge.
REQ-030 When DISP_SCHED_IDLE_PATTERN_EN is undefined, REQ-024 applies and IDLE_VAL is unused.

Structure
REQ-031 Package disp_sched_pkg SHALL hold the state enum (IDLE/LOAD/HOLD) and the default TICK_DIV and HOLD_TICKS constants.
REQ-032 The tick generator SHALL be sub-module disp_tick_gen (param TICK_DIV; ports clk5, reset, tick).

Verification (bench uses TICK_DIV=4, HOLD_TICKS=3)
REQ-033 Reset release, req=00 for 50 cycles -> dispVal=0000, point=0, ack never high, busy=0.
REQ-034 req=01 with val0=16'h1234, pt0=4'b0010 -> ack=01 pulses once; dispVal=1234, point=0010; busy high for 9..12 cycles, then IDLE.
REQ-035 req=11 from reset, held -> grants alternate 0,1,0,1 with values val0/val1 respectively; ack never 11.
REQ-036 req=10 raised mid-HOLD of requester 0 -> no ack until HOLD ends, then ack=10 within 2 cycles.
REQ-037 reset pulsed on the LOAD cycle -> ack=00 next cycle, dispVal=0000, owner=1.
REQ-038 With DISP_SCHED_IDLE_PATTERN_EN and IDLE_VAL=16'hDEAD: grant 16'h1234, let HOLD expire with req=00 -> dispVal=DEAD, point=0; without the macro, dispVal stays 1234.

Source files
------------

// File: rtl/disp_sched_pkg.sv
// Shared types and defaults for the two-requester display scheduler.
package disp_sched_pkg;

    localparam int unsigned DEF_TICK_DIV   = 5000;
    localparam int unsigned DEF_HOLD_TICKS = 500;
    localparam int unsigned VAL_W          = 16;
    localparam int unsigned PT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Round-robin pick: a lone request wins, a tie goes to the non-owner.
    function automatic logic pick_winner(input logic [1:0] req, input logic owner);
        logic w;
        if (req == 2'b11) begin
            w = ~owner;
        end else begin
            w = req[1];
        end
        return w;
    endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clk5 cycles.
module disp_tick_gen
    import disp_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk5,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Count 0..TICK_DIV-1; tick is registered so it is high exactly while r_cnt is at its last value.
    always_ff @(posedge clk5) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
            r_tick <= (r_cnt == CNT_PRE);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/disp_scheduler.sv
// Two-requester display arbiter: grant, load one value, hold it for a number of ticks.
// Optional feature macro: DISP_SCHED_IDLE_PATTERN_EN (show IDLE_VAL whenever the display goes idle).
module disp_scheduler
    import disp_sched_pkg::*;
#(
    parameter int unsigned      TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned      HOLD_TICKS = DEF_HOLD_TICKS,
    parameter logic [VAL_W-1:0] IDLE_VAL   = 16'h0000
) (
    input  logic             clk5,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [VAL_W-1:0] val0,
    input  logic [VAL_W-1:0] val1,
    input  logic [PT_W-1:0]  pt0,
    input  logic [PT_W-1:0]  pt1,
    output logic [1:0]       ack,
    output logic [VAL_W-1:0] dispVal,
    output logic [PT_W-1:0]  point,
    output logic             busy,
    output logic             owner
);

    localparam int unsigned      HOLD_W    = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

`ifdef DISP_SCHED_IDLE_PATTERN_EN
    localparam bit IDLE_PAT_EN = 1'b1;
`else
    localparam bit IDLE_PAT_EN = 1'b0;
`endif

    state_t            r_state;
    logic              r_winner;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_idle_new;
    logic [1:0]        r_ack;
    logic [VAL_W-1:0]  r_disp;
    logic [PT_W-1:0]   r_point;
    logic              r_busy;
    logic              r_owner;

    logic w_tick;
    logic w_winner;
    logic w_hold_done;

    disp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk5  (clk5),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_winner = pick_winner(req, r_owner);

    // Hold ends on the tick that brings the count to HOLD_TICKS (or if it is already there).
    assign w_hold_done = (r_hold_cnt == HOLD_MAX) ||
                         (w_tick && (r_hold_cnt == HOLD_LAST));

    // Scheduler FSM with all outputs registered alongside the state.
    always_ff @(posedge clk5) begin
        if (reset) begin
            r_state    <= IDLE;
            r_winner   <= 1'b0;
            r_hold_cnt <= '0;
            r_idle_new <= 1'b0;
            r_ack      <= 2'b00;
            r_disp     <= '0;
            r_point    <= '0;
            r_busy     <= 1'b0;
            r_owner    <= 1'b1;
        end else begin
            r_ack <= 2'b00;
            case (r_state)
                IDLE: begin
                    r_idle_new <= 1'b0;
                    if (req != 2'b00) begin
                        r_winner <= w_winner;
                        r_state  <= LOAD;
                        r_busy   <= 1'b1;
                    end else if (IDLE_PAT_EN && r_idle_new) begin
                        r_disp  <= IDLE_VAL;
                        r_point <= '0;
                    end
                end
                LOAD: begin
                    r_disp     <= r_winner ? val1 : val0;
                    r_point    <= r_winner ? pt1 : pt0;
                    r_ack      <= r_winner ? 2'b10 : 2'b01;
                    r_owner    <= r_winner;
                    // A tick landing on the LOAD cycle already counts toward the hold.
                    r_hold_cnt <= w_tick ? HOLD_W'(1) : '0;
                    r_state    <= HOLD;
                end
                HOLD: begin
                    if (w_tick && (r_hold_cnt != HOLD_MAX)) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                    if (w_hold_done) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_idle_new <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack     = r_ack;
    assign dispVal = r_disp;
    assign point   = r_point;
    assign busy    = r_busy;
    assign owner   = r_owner;

endmodule

// File: tb/tb_disp_scheduler.sv
// Bench for disp_scheduler: cycle model built from grant/hold timing rules plus directed checks.
module tb_disp_scheduler;

    localparam int          TD     = 4;
    localparam int          HT     = 3;
    localparam logic [15:0] IDLE_V = 16'hDEAD;
`ifdef DISP_SCHED_IDLE_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic        clk5  = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req   = 2'b00;
    logic [15:0] val0  = 16'h0000;
    logic [15:0] val1  = 16'h0000;
    logic [3:0]  pt0   = 4'h0;
    logic [3:0]  pt1   = 4'h0;
    logic [1:0]  ack;
    logic [15:0] dispVal;
    logic [3:0]  point;
    logic        busy;
    logic        owner;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk5 = ~clk5;

    disp_scheduler #(
        .TICK_DIV   (TD),
        .HOLD_TICKS (HT),
        .IDLE_VAL   (IDLE_V)
    ) u_dut (
        .clk5    (clk5),
        .reset   (reset),
        .req     (req),
        .val0    (val0),
        .val1    (val1),
        .pt0     (pt0),
        .pt1     (pt1),
        .ack     (ack),
        .dispVal (dispVal),
        .point   (point),
        .busy    (busy),
        .owner   (owner)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: cycle m_n is the interval after the m_n-th edge since reset; ticks fall on m_n % TD == TD-1.
    int          m_n     = 0;
    int          m_load  = -10;
    int          m_end   = -10;
    int          m_entry = -10;
    int          m_f     = 0;
    bit          m_idle  = 1'b1;
    bit          m_win   = 1'b0;
    bit          m_valid = 1'b0;
    logic [1:0]  e_ack   = 2'b00;
    logic [15:0] e_disp  = 16'h0000;
    logic [3:0]  e_point = 4'h0;
    bit          e_busy  = 1'b0;
    bit          e_owner = 1'b1;

    initial forever begin
        @(posedge clk5);
        if (reset) begin
            m_n = 0; m_load = -10; m_end = -10; m_entry = -10;
            m_idle = 1'b1; m_valid = 1'b1;
            e_ack = 2'b00; e_disp = 16'h0000; e_point = 4'h0; e_busy = 1'b0; e_owner = 1'b1;
        end else begin
            e_ack = 2'b00;
            if (m_n == m_load) begin
                e_disp  = m_win ? val1 : val0;
                e_point = m_win ? pt1 : pt0;
                e_ack   = m_win ? 2'b10 : 2'b01;
                e_owner = m_win;
            end
            if (PAT_EN && m_idle && (m_n == m_entry) && (req == 2'b00)) begin
                e_disp  = IDLE_V;
                e_point = 4'h0;
            end
            if (m_idle && (req != 2'b00)) begin
                m_win  = (req == 2'b11) ? ~e_owner : req[1];
                m_load = m_n + 1;
                m_f    = m_load;
                while ((m_f % TD) != TD - 1) m_f++;
                m_end  = m_f + (HT - 1) * TD;
                m_idle = 1'b0;
            end else if (!m_idle && (m_n == m_end)) begin
                m_idle  = 1'b1;
                m_entry = m_n + 1;
            end
            m_n++;
            e_busy = !m_idle;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    initial forever begin
        @(negedge clk5);
        if (m_valid) begin
            chk("ack",     32'(ack),     32'(e_ack));
            chk("dispVal", 32'(dispVal), 32'(e_disp));
            chk("point",   32'(point),   32'(e_point));
            chk("busy",    32'(busy),    32'(e_busy));
            chk("owner",   32'(owner),   32'(e_owner));
            chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
        end
    end

    task automatic do_reset();
        @(negedge clk5);
        reset = 1'b1;
        req   = 2'b00;
        repeat (2) @(negedge clk5);
        reset = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk5);
            if (ack != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk5);
            if (busy == lvl) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        int          cnt;
        int          acks;
        bit          ok;
        logic [1:0]  av;
        logic [15:0] dv;
        logic [3:0]  pv;

        // Reset state, then 50 idle cycles.
        repeat (3) @(negedge clk5);
        chk("rst_dispVal", 32'(dispVal), 32'h0000);
        chk("rst_point",   32'(point),   32'h0);
        chk("rst_ack",     32'(ack),     32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_owner",   32'(owner),   32'h1);
        reset = 1'b0;
        acks = 0;
        repeat (50) begin
            @(negedge clk5);
            if (ack != 2'b00) acks++;
        end
        chk("idle_acks",    32'(acks),    32'd0);
        chk("idle_dispVal", 32'(dispVal), 32'h0000);
        chk("idle_busy",    32'(busy),    32'h0);

        // Single grant from requester 0; measure busy length.
        val0 = 16'h1234; pt0 = 4'b0010; req = 2'b01;
        cnt = 0; acks = 0; ok = 1'b0; av = 2'b00; dv = 16'h0; pv = 4'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk5);
            if (busy) cnt++;
            if (ack != 2'b00) begin
                acks++; av = ack; dv = dispVal; pv = point; req = 2'b00;
            end
            if ((cnt > 0) && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("b_done",     32'(ok),        32'd1);
        chk("b_ack",      32'(av),        32'b01);
        chk("b_dispVal",  32'(dv),        32'h1234);
        chk("b_point",    32'(pv),        32'b0010);
        chk("b_ackcount", 32'(acks),      32'd1);
        chk("b_busy_min", 32'(cnt >= 9),  32'd1);
        chk("b_busy_max", 32'(cnt <= 12), 32'd1);

        // Both requesting from reset: grants alternate 0,1,0,1.
        do_reset();
        val0 = 16'hAAAA; pt0 = 4'h1; val1 = 16'h5555; pt1 = 4'h8; req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_ack("c_ack_seen");
            chk("c_ack",     32'(ack),     (g % 2 == 0) ? 32'b01 : 32'b10);
            chk("c_dispVal", 32'(dispVal), (g % 2 == 0) ? 32'hAAAA : 32'h5555);
            chk("c_point",   32'(point),   (g % 2 == 0) ? 32'h1 : 32'h8);
        end
        req = 2'b00;

        // Requester 1 arrives mid-hold: ignored until idle, then acked two cycles after hold ends.
        do_reset();
        val0 = 16'h1111; pt0 = 4'h1; req = 2'b01;
        wait_ack("d_ack0_seen");
        chk("d_ack0", 32'(ack), 32'b01);
        req = 2'b00;
        repeat (3) @(negedge clk5);
        val1 = 16'h2222; pt1 = 4'h4; req = 2'b10;
        acks = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk5);
            if (ack != 2'b00) acks++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("d_hold_end",  32'(ok),   32'd1);
        chk("d_hold_acks", 32'(acks), 32'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk5);
            cnt++;
            if (ack != 2'b00) break;
        end
        chk("d_ack_delay", 32'(cnt),     32'd2);
        chk("d_ack1",      32'(ack),     32'b10);
        chk("d_dispVal",   32'(dispVal), 32'h2222);
        req = 2'b00;

        // Reset on the LOAD cycle aborts the grant.
        wait_busy(1'b0, "e_idle_seen");
        val0 = 16'hBEEF; pt0 = 4'hF; req = 2'b01;
        wait_busy(1'b1, "e_load_seen");
        reset = 1'b1;
        req   = 2'b00;
        @(negedge clk5);
        chk("e_ack",     32'(ack),     32'h0);
        chk("e_dispVal", 32'(dispVal), 32'h0000);
        chk("e_point",   32'(point),   32'h0);
        chk("e_owner",   32'(owner),   32'h1);
        reset = 1'b0;
        repeat (2) @(negedge clk5);

        // Display contents once the hold expires with no requests.
        do_reset();
        val0 = 16'h1234; pt0 = 4'b0010; req = 2'b01;
        wait_ack("f_ack_seen");
        req = 2'b00;
        wait_busy(1'b0, "f_idle_seen");
        repeat (2) @(negedge clk5);
        chk("f_dispVal", 32'(dispVal), PAT_EN ? 32'hDEAD : 32'h1234);
        chk("f_point",   32'(point),   PAT_EN ? 32'h0 : 32'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
